// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl -- timed row scanner and debouncer for a 4x4 matrix keypad.
// Each row is driven for SCAN_DIV cycles and the synchronized columns are
// sampled on the final cycle of that dwell. A frame is four rows. A single key
// must appear on its own for DEBOUNCE_SCANS consecutive frames before its code
// is posted. Frames with more than one key are rejected as ghosts. The posted
// code is held in a one-entry register with a valid/ack handshake.
//
// Ports:
//   clk        module clock
//   rst        synchronous reset, active-high
//   key_in     column inputs, active-high; bit3 = leftmost column
//   key_out    one-hot row drive; bit0 = top row
//   key_code   code of the accepted key; meaningful while key_valid=1
//   key_valid  event pending; held until accepted with key_ack
//   key_ack    consumer accept; only acts while key_valid=1
//   key_held   level, 1 while the debounced key is down
//   overflow   sticky; an event was dropped because one was still pending
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic [3:0] key_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overflow
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [4:0]  DEB_N    = 5'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEB, PRESSED} state_t;

  state_t      state;
  logic [3:0]  sync1, sync2;
  logic [15:0] cnt;
  logic [1:0]  row;
  logic        acc_hit, acc_multi;
  logic [3:0]  acc_code;
  logic [3:0]  cand;
  logic [3:0]  deb_cnt, rel_cnt;

  logic        dwell_end, frame_end;
  logic        samp_one, samp_multi;
  logic [1:0]  samp_col;
  logic [3:0]  samp_code;
  logic        f_one, f_none, f_multi;
  logic [3:0]  f_code;
  logic        post;
  logic        ack_ok;

  // Keypad legend, indexed by {row, column} with column 0 = leftmost.
  function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'd0:  k = 4'h1;  4'd1:  k = 4'h2;  4'd2:  k = 4'h3;  4'd3:  k = 4'hA;
      4'd4:  k = 4'h4;  4'd5:  k = 4'h5;  4'd6:  k = 4'h6;  4'd7:  k = 4'hB;
      4'd8:  k = 4'h7;  4'd9:  k = 4'h8;  4'd10: k = 4'h9;  4'd11: k = 4'hC;
      4'd12: k = 4'hE;  4'd13: k = 4'h0;  4'd14: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  always_comb begin
    dwell_end  = (cnt == DIV_LAST);
    frame_end  = dwell_end && (row == 2'd3);
    samp_one   = 1'b1;
    samp_col   = 2'd0;
    case (sync2)
      4'b1000: samp_col = 2'd0;
      4'b0100: samp_col = 2'd1;
      4'b0010: samp_col = 2'd2;
      4'b0001: samp_col = 2'd3;
      default: samp_one = 1'b0;
    endcase
    samp_multi = (sync2 != 4'b0000) && !samp_one;
    samp_code  = key_lut(row, samp_col);

    // Frame verdict folds the row-3 sample in with the rows already seen.
    f_multi = acc_multi || samp_multi || (acc_hit && samp_one);
    f_one   = !f_multi && (acc_hit || samp_one);
    f_none  = !f_multi && !f_one;
    f_code  = samp_one ? samp_code : acc_code;

    post = 1'b0;
    if (frame_end && f_one) begin
      if (state == IDLE && DEB_N == 5'd1)
        post = 1'b1;
      else if (state == DEB && f_code == cand && ({1'b0, deb_cnt} + 5'd1) == DEB_N)
        post = 1'b1;
    end
    ack_ok = key_valid && key_ack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      cnt       <= '0;
      row       <= '0;
      key_out   <= 4'b0001;
      acc_hit   <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= '0;
      state     <= IDLE;
      cand      <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;

      if (dwell_end) begin
        cnt     <= '0;
        row     <= row + 2'd1;
        key_out <= {key_out[2:0], key_out[3]};
        if (row == 2'd3) begin
          acc_hit   <= 1'b0;
          acc_multi <= 1'b0;
        end else begin
          acc_multi <= acc_multi || samp_multi || (acc_hit && samp_one);
          acc_hit   <= acc_hit || samp_one;
          if (samp_one)
            acc_code <= samp_code;
        end
      end else begin
        cnt <= cnt + 16'd1;
      end

      if (frame_end) begin
        case (state)
          IDLE: begin
            if (f_one) begin
              cand <= f_code;
              if (DEB_N == 5'd1) begin
                state    <= PRESSED;
                key_held <= 1'b1;
                rel_cnt  <= '0;
              end else begin
                state   <= DEB;
                deb_cnt <= 4'd1;
              end
            end
          end
          DEB: begin
            if (f_one && f_code == cand) begin
              deb_cnt <= deb_cnt + 4'd1;
              if (({1'b0, deb_cnt} + 5'd1) == DEB_N) begin
                state    <= PRESSED;
                key_held <= 1'b1;
                rel_cnt  <= '0;
              end
            end else begin
              state   <= IDLE;
              deb_cnt <= '0;
            end
          end
          PRESSED: begin
            if (f_none) begin
              if (({1'b0, rel_cnt} + 5'd1) == DEB_N) begin
                state    <= IDLE;
                key_held <= 1'b0;
                rel_cnt  <= '0;
                deb_cnt  <= '0;
              end else begin
                rel_cnt <= rel_cnt + 4'd1;
              end
            end else begin
              rel_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // An ack on the posting cycle frees the slot for the new code.
      if (ack_ok)
        overflow <= 1'b0;
      if (post) begin
        if (!key_valid || key_ack) begin
          key_code  <= f_code;
          key_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (ack_ok) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// A keypad matrix model drives key_in from key_out and the set of pressed keys.
// Expected key codes are queued when a press is applied and compared when the
// design raises key_valid.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       overflow;

  logic [15:0] pressed;
  logic [3:0]  exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Key indices in the pressed mask: row*4 + column (column 0 = leftmost).
  localparam int K1 = 0, K2 = 1, K5 = 5, K6 = 6, K9 = 10, K0 = 13, KHASH = 14;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_out(key_out),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_held(key_held), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @* begin
    key_in = 4'b0000;
    for (int r = 0; r < 4; r++)
      if (key_out[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) key_in[3-c] = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_event(input string tag, input int budget);
    int n;
    logic [3:0] e;
    n = 0;
    while (!key_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 32'(key_valid), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
    check_eq({tag, "_code"}, 32'(key_code), 32'(e));
  endtask

  task automatic wait_release(input string tag, input int budget);
    int n;
    n = 0;
    while (key_held && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_released"}, 32'(key_held), 32'd0);
  endtask

  // Returns at the negedge just before the posedge that evaluates a frame.
  task automatic wait_eval();
    int n;
    n = 0;
    while (key_out == 4'b1000 && n < 20) begin @(negedge clk); n++; end
    while (key_out != 4'b1000 && n < 40) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check_eq("scan_phase", 32'(n < 40), 32'd1);
  endtask

  task automatic do_ack();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_key_out"},   32'(key_out),   32'h1);
    check_eq({tag, "_key_code"},  32'(key_code),  32'h0);
    check_eq({tag, "_key_valid"}, 32'(key_valid), 32'h0);
    check_eq({tag, "_key_held"},  32'(key_held),  32'h0);
    check_eq({tag, "_overflow"},  32'(overflow),  32'h0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    key_ack = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst0");

    // Idle scan: each row driven for 4 cycles in order.
    for (int i = 0; i < 16; i++) begin
      check_eq("scan_row", 32'(key_out), 32'(4'b0001 << (i / 4)));
      @(negedge clk);
    end
    check_eq("idle_valid", 32'(key_valid), 32'd0);
    check_eq("idle_held", 32'(key_held), 32'd0);

    // Single clean press of '5'.
    pressed[K5] = 1'b1;
    exp_q.push_back(4'h5);
    expect_event("k5", 67);
    check_eq("k5_held", 32'(key_held), 32'd1);
    do_ack();
    check_eq("k5_acked", 32'(key_valid), 32'd0);
    repeat (40) @(negedge clk);
    pressed = '0;
    wait_release("k5", 64);
    repeat (64) @(negedge clk);
    check_eq("k5_no_repeat", 32'(key_valid), 32'd0);

    // Bounce on '9': two short bursts must not post.
    pressed[K9] = 1'b1; repeat (32) @(negedge clk);
    pressed = '0;       repeat (16) @(negedge clk);
    pressed[K9] = 1'b1; repeat (32) @(negedge clk);
    pressed = '0;       repeat (32) @(negedge clk);
    check_eq("bounce_valid", 32'(key_valid), 32'd0);
    check_eq("bounce_held", 32'(key_held), 32'd0);
    pressed[K9] = 1'b1;
    exp_q.push_back(4'h9);
    expect_event("k9", 67);
    do_ack();
    pressed = '0;
    wait_release("k9", 80);

    // Ghosting: two keys in different rows, then two in one row.
    pressed[K1] = 1'b1; pressed[K6] = 1'b1;
    repeat (80) @(negedge clk);
    check_eq("ghost16_valid", 32'(key_valid), 32'd0);
    check_eq("ghost16_held", 32'(key_held), 32'd0);
    pressed = '0;
    pressed[K1] = 1'b1; pressed[K2] = 1'b1;
    repeat (80) @(negedge clk);
    check_eq("ghost12_valid", 32'(key_valid), 32'd0);
    check_eq("ghost12_held", 32'(key_held), 32'd0);
    pressed = '0;
    repeat (32) @(negedge clk);

    // Overflow: '#' pending, '0' debounced without an ack is dropped.
    pressed[KHASH] = 1'b1;
    exp_q.push_back(4'hF);
    expect_event("khash", 67);
    pressed = '0;
    wait_release("khash", 80);
    pressed[K0] = 1'b1;
    repeat (80) @(negedge clk);
    check_eq("ovf_held", 32'(key_held), 32'd1);
    check_eq("ovf_code", 32'(key_code), 32'hF);
    check_eq("ovf_valid", 32'(key_valid), 32'd1);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    pressed = '0;
    wait_release("k0_drop", 80);
    do_ack();
    check_eq("ovf_ack_valid", 32'(key_valid), 32'd0);
    check_eq("ovf_ack_flag", 32'(overflow), 32'd0);

    // Ack coinciding with the post of '0' replaces the pending '#'.
    pressed[KHASH] = 1'b1;
    exp_q.push_back(4'hF);
    expect_event("khash2", 67);
    pressed = '0;
    wait_release("khash2", 80);
    wait_eval();
    pressed[K0] = 1'b1;
    exp_q.push_back(4'h0);
    wait_eval();
    wait_eval();
    wait_eval();
    check_eq("pre_post_valid", 32'(key_valid), 32'd1);
    do_ack();
    expect_event("k0_same_cycle", 1);
    check_eq("same_cycle_ovf", 32'(overflow), 32'd0);
    pressed = '0;
    wait_release("k0", 80);
    do_ack();

    // Reset mid-debounce, then a held key must debounce from scratch.
    pressed[K5] = 1'b1;
    wait_eval();
    wait_eval();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_deb");
    exp_q.push_back(4'h5);
    n = 0;
    while (!key_valid && n < 67) begin
      @(negedge clk);
      n++;
    end
    check_eq("redeb_min_latency", 32'(n >= 40), 32'd1);
    expect_event("k5_redeb", 1);

    // Reset with an event pending.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_pend");
    pressed = '0;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
